// File: rtl/fetch_if.sv
// Fetch-unit bus bundle: memory read handshake, instruction register handshake, PC redirect.
// master = fetch_unit, slave = memory plus execute stage; no storage or latency of its own.
interface fetch_if #(
  parameter int ADDR_W = 16
);
  logic              en;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_rdata;
  logic              ir_valid;
  logic [15:0]       instr;
  logic [3:0]        codeop;
  logic              ir_ready;
  logic              jmp_take;
  logic [ADDR_W-1:0] jmp_target;
  logic [ADDR_W-1:0] pc;

  modport master (
    input  en, mem_ack, mem_rdata, ir_ready, jmp_take, jmp_target,
    output mem_req, mem_addr, ir_valid, instr, codeop, pc
  );

  modport slave (
    output en, mem_ack, mem_rdata, ir_ready, jmp_take, jmp_target,
    input  mem_req, mem_addr, ir_valid, instr, codeop, pc
  );
endinterface

// File: rtl/fetch_unit.sv
// LITE-16 fetch sequencer: ack->ir_valid 1 cycle, consume->next mem_req 1 cycle (2 cycles/instr at best).
// Backpressure: without ir_ready the instruction is held and no new request is issued.
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       instr_q;
  logic              mem_req_c;
  logic              ir_valid_c;
  logic              capture;
  logic              consume;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An issued request always runs to its ack; en only gates starting a new one.
  always_comb begin
    state_d    = state_q;
    mem_req_c  = 1'b0;
    ir_valid_c = 1'b0;
    capture    = 1'b0;
    consume    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en) state_d = FETCH;
      end
      FETCH: begin
        mem_req_c = 1'b1;
        if (bus.mem_ack) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        ir_valid_c = 1'b1;
        if (bus.ir_ready) begin
          consume = 1'b1;
          state_d = bus.en ? FETCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      if (capture) instr_q <= bus.mem_rdata;
      // Natural ADDR_W-bit wrap on increment.
      if (consume) pc_q <= bus.jmp_take ? bus.jmp_target : pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.mem_req  = mem_req_c;
  assign bus.mem_addr = pc_q;
  assign bus.ir_valid = ir_valid_c;
  assign bus.instr    = instr_q;
  assign bus.codeop   = instr_q[15:12];
  assign bus.pc       = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a transaction-level model.
module tb_fetch_unit;
  localparam int          AW  = 16;
  localparam logic [15:0] RPC = 16'h0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_if #(.ADDR_W(AW)) bus ();

  fetch_unit #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] w;
    if (a == 16'h0000) return 16'hE123;
    w = a * 16'h9E37 + 16'h1234;
    return w;
  endfunction

  // Model: a request is outstanding, or an instruction is held, or neither.
  int          m_pc;
  bit          m_req;
  bit          m_valid;
  logic [15:0] m_instr;

  initial begin
    m_pc = RPC; m_req = 0; m_valid = 0; m_instr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_pc = RPC; m_req = 0; m_valid = 0; m_instr = '0;
      end
      chk("mem_req",  bus.mem_req,  m_req);
      chk("mem_addr", bus.mem_addr, m_pc);
      chk("pc",       bus.pc,       m_pc);
      chk("ir_valid", bus.ir_valid, m_valid);
      chk("instr",    bus.instr,    m_instr);
      chk("codeop",   bus.codeop,   m_instr >> 12);
      // Inputs are stable from here to the next rising edge: predict its effect.
      if (rst_n) begin
        if (m_req) begin
          if (bus.mem_ack) begin
            m_instr = bus.mem_rdata;
            m_req   = 0;
            m_valid = 1;
          end
        end else if (m_valid) begin
          if (bus.ir_ready) begin
            m_pc    = bus.jmp_take ? int'(bus.jmp_target) : (m_pc + 1) % 65536;
            m_valid = 0;
            m_req   = bus.en;
          end
        end else begin
          m_req = bus.en;
        end
      end
    end
  end

  // Memory responder: acks after resp_delay wait cycles; optional junk acks while idle.
  bit resp_spur = 0;
  bit resp_rand = 0;
  int resp_delay = 0;
  int wcnt = 0;

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_req) begin
        if (wcnt >= resp_delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_word(bus.mem_addr);
          wcnt = 0;
          if (resp_rand) resp_delay = $urandom_range(0, 3);
        end else begin
          bus.mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        wcnt = 0;
        bus.mem_ack   = resp_spur ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.mem_rdata = 16'($urandom);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.ir_valid && n < 50) begin tick(); n++; end
    chk(name, bus.ir_valid, 1);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!bus.mem_req && n < 50) begin tick(); n++; end
    chk(name, bus.mem_req, 1);
  endtask

  initial begin
    int n2;
    bit found;
    rst_n          = 1'b0;
    bus.en         = 1'b0;
    bus.ir_ready   = 1'b0;
    bus.jmp_take   = 1'b0;
    bus.jmp_target = '0;
    repeat (3) tick();
    chk("rst_req",    bus.mem_req,  0);
    chk("rst_addr",   bus.mem_addr, 0);
    chk("rst_pc",     bus.pc,       0);
    chk("rst_valid",  bus.ir_valid, 0);
    chk("rst_instr",  bus.instr,    0);
    chk("rst_codeop", bus.codeop,   0);

    // Reset release and first zero-wait fetch
    bus.en = 1'b1;
    rst_n  = 1'b1;
    tick();
    chk("first_req",  bus.mem_req,  1);
    chk("first_addr", bus.mem_addr, 16'h0000);
    tick();
    chk("first_valid",  bus.ir_valid, 1);
    chk("first_instr",  bus.instr,    16'hE123);
    chk("first_codeop", bus.codeop,   4'hE);

    // Backpressure; a jump request without ir_ready must be ignored
    bus.jmp_take   = 1'b1;
    bus.jmp_target = 16'h0BAD;
    repeat (5) begin
      tick();
      chk("bp_instr", bus.instr,    16'hE123);
      chk("bp_pc",    bus.pc,       16'h0000);
      chk("bp_req",   bus.mem_req,  0);
      chk("bp_valid", bus.ir_valid, 1);
    end
    bus.jmp_take = 1'b0;
    bus.ir_ready = 1'b1;
    resp_delay   = 3;
    tick();
    chk("bp_release_req",  bus.mem_req,  1);
    chk("bp_release_addr", bus.mem_addr, 16'h0001);

    // Three wait states per request
    n2 = 0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.ir_valid && bus.pc == 16'h0004) begin found = 1; break; end
      if (bus.mem_req && bus.mem_addr == 16'h0002) n2++;
      tick();
    end
    chk("ws_reach_pc4",   found, 1);
    chk("ws_addr2_cycles", n2,   4);

    // Jump on consume of the instruction at 0x0004
    bus.jmp_take   = 1'b1;
    bus.jmp_target = 16'h0100;
    tick();
    bus.jmp_take = 1'b0;
    chk("jmp_req",  bus.mem_req,  1);
    chk("jmp_addr", bus.mem_addr, 16'h0100);

    // Wrap from 0xFFFF to 0x0000
    resp_delay = 0;
    wait_valid("wrap_wait_0100");
    bus.jmp_take   = 1'b1;
    bus.jmp_target = 16'hFFFF;
    tick();
    bus.jmp_take = 1'b0;
    chk("wrap_jmp_addr", bus.mem_addr, 16'hFFFF);
    wait_valid("wrap_wait_ffff");
    chk("wrap_pc_ffff", bus.pc, 16'hFFFF);
    resp_delay = 2;
    tick();
    chk("wrap_req",  bus.mem_req,  1);
    chk("wrap_addr", bus.mem_addr, 16'h0000);

    // Dropping en mid-fetch still completes the fetch, then goes idle
    bus.en = 1'b0;
    wait_valid("en_drop_completes");
    chk("en_drop_pc", bus.pc, 16'h0000);
    tick();
    chk("en_drop_idle_req",   bus.mem_req,  0);
    chk("en_drop_idle_valid", bus.ir_valid, 0);
    tick();
    chk("en_drop_stays_idle", bus.mem_req,  0);
    chk("en_drop_pc_next",    bus.pc,       16'h0001);

    // Asynchronous reset during a pending fetch
    resp_delay = 5;
    bus.en     = 1'b1;
    wait_req("rst_mid_req_seen");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_req",   bus.mem_req,  0);
    chk("rst_async_pc",    bus.pc,       RPC);
    chk("rst_async_valid", bus.ir_valid, 0);
    chk("rst_async_instr", bus.instr,    0);
    tick();
    rst_n = 1'b1;

    // Random traffic
    resp_rand = 1;
    resp_spur = 1;
    for (int i = 0; i < 3000; i++) begin
      bus.en         = ($urandom_range(0, 9) != 0);
      bus.ir_ready   = 1'($urandom_range(0, 1));
      bus.jmp_take   = ($urandom_range(0, 3) == 0);
      bus.jmp_target = 16'($urandom);
      tick();
    end
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
